// File: rtl/trace_uart_tx.sv
// Trace transmitter: snapshots pc/inst and the 32 GPRs through a debug read port,
// then streams a 137-byte frame (sync, pc, inst, regs, MSB first) over UART 8N1.
module trace_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        trace_valid,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_data,
  output logic        stall_req,
  output logic        busy,
  output logic [7:0]  drop_cnt,
  output logic        tx
);

  localparam int unsigned CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BIT_W      = 4;
  localparam int unsigned LAST_BYTE  = 136;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, SNAP, SEND} state_t;

  state_t            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tx_q, tx_d;
  logic [7:0]        drop_q, drop_d;
  logic              load_bit;
  logic [6:0]        reg_off;
  logic [1:0]        byte_sel;
  logic [31:0]       word_sel;
  logic [7:0]        frame_byte;

  logic [31:0] pc_q, inst_q;
  logic [31:0] snap_mem [32];

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    word_byte = w[31:24];
      2'd1:    word_byte = w[23:16];
      2'd2:    word_byte = w[15:8];
      default: word_byte = w[7:0];
    endcase
  endfunction

  // State and counters
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      drop_q  <= drop_d;
    end
  end

  // Capture storage; contents are don't-care after reset
  always_ff @(posedge clk_in) begin
    if (state_q == IDLE && trace_valid) begin
      pc_q   <= pc;
      inst_q <= inst;
    end
    if (state_q == SNAP) snap_mem[idx_q] <= dbg_data;
  end

  // Next-state, frame byte selection and next tx bit
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    drop_d   = drop_q;
    load_bit = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (trace_valid) begin
          state_d = SNAP;
          idx_d   = '0;
        end
      end
      SNAP: begin
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d  = SEND;
          byte_d   = '0;
          bit_d    = '0;
          cnt_d    = '0;
          load_bit = 1'b1;
        end
      end
      SEND: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_W'(9)) begin
            bit_d = '0;
            if (byte_q == BYTE_W'(LAST_BYTE)) begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end else begin
              byte_d   = byte_q + BYTE_W'(1);
              load_bit = 1'b1;
            end
          end else begin
            bit_d    = bit_q + BIT_W'(1);
            load_bit = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && trace_valid && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

    // Byte layout: 0 sync, 1..4 pc, 5..8 inst, 9..136 registers
    reg_off  = 7'(byte_d - BYTE_W'(9));
    byte_sel = reg_off[1:0];
    word_sel = snap_mem[reg_off[6:2]];
    if (byte_d < BYTE_W'(5)) begin
      byte_sel = 2'(byte_d - BYTE_W'(1));
      word_sel = pc_q;
    end else if (byte_d < BYTE_W'(9)) begin
      byte_sel = 2'(byte_d - BYTE_W'(5));
      word_sel = inst_q;
    end
    frame_byte = (byte_d == '0) ? SYNC_BYTE : word_byte(word_sel, byte_sel);

    if (load_bit) begin
      if (bit_d == '0)              tx_d = 1'b0;
      else if (bit_d == BIT_W'(9))  tx_d = 1'b1;
      else                          tx_d = frame_byte[3'(bit_d - BIT_W'(1))];
    end
  end

  assign dbg_addr  = idx_q;
  assign stall_req = (state_q == SNAP);
  assign busy      = (state_q != IDLE);
  assign drop_cnt  = drop_q;
  assign tx        = tx_q;

endmodule

// File: tb/tb_trace_uart_tx.sv
// Directed bench for trace_uart_tx at 4 clocks per bit: decodes each frame off tx
// and compares against hand-written headers and a register-file pattern model.
module tb_trace_uart_tx;

  localparam int unsigned CPB    = 4;
  localparam int unsigned NBYTES = 137;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic        trace_valid = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] inst = '0;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        stall_req, busy, tx;
  logic [7:0]  drop_cnt;
  logic [31:0] regs [32];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_in = ~clk_in;

  assign dbg_data = regs[dbg_addr];

  trace_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk_in(clk_in), .reset(reset), .trace_valid(trace_valid), .pc(pc), .inst(inst),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .stall_req(stall_req), .busy(busy),
    .drop_cnt(drop_cnt), .tx(tx)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] mul;
    int          drops;
    logic [71:0] hdr;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk_in);
    #2 reset = 1'b1;
    #1;
    check({tag, "_tx"}, 128'(tx), 128'(1));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_stall"}, 128'(stall_req), 128'(0));
    check({tag, "_drop"}, 128'(drop_cnt), 128'(0));
    check({tag, "_dbg_addr"}, 128'(dbg_addr), 128'(0));
    @(negedge clk_in);
    reset = 1'b0;
  endtask

  // Accept one request, walk the snapshot window, decode the frame off tx.
  task automatic run_vector(input int v, input string tag);
    logic [7:0]  got [NBYTES];
    logic [7:0]  byte_v;
    logic [9:0]  bits0;
    logic [9:0]  exp_bits;
    logic [71:0] hdr_got;
    logic [7:0]  exp_b;
    logic        first, last_busy;
    int          stall_err, tim_err, reg_err;

    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * vecs[v].mul;
    @(negedge clk_in);
    pc = vecs[v].pc;
    inst = vecs[v].inst;
    trace_valid = 1'b1;
    @(negedge clk_in);
    trace_valid = 1'b0;

    stall_err = 0;
    for (int n = 0; n < 32; n++) begin
      if (!(stall_req === 1'b1 && busy === 1'b1 && dbg_addr === 5'(n))) stall_err++;
      pc = $urandom;
      inst = $urandom;
      @(negedge clk_in);
    end
    check({tag, "_stall_window"}, 128'(stall_err), 128'(0));
    check({tag, "_stall_release"}, 128'(stall_req), 128'(0));

    tim_err = 0;
    bits0 = '0;
    last_busy = 1'b0;
    for (int b = 0; b < int'(NBYTES); b++) begin
      byte_v = '0;
      for (int j = 0; j < 10; j++) begin
        first = tx;
        for (int c = 0; c < int'(CPB); c++) begin
          if (tx !== first) tim_err++;
          if (b == 0 && c == 0) bits0[j] = tx;
          if (j == 0 && b >= 10 && b < 10 + vecs[v].drops && c < 2) trace_valid = (c == 0);
          if (b == int'(NBYTES) - 1 && j == 9 && c == int'(CPB) - 1) last_busy = busy;
          @(negedge clk_in);
        end
        if (j == 0 && first !== 1'b0) tim_err++;
        else if (j == 9 && first !== 1'b1) tim_err++;
        else if (j >= 1 && j <= 8) byte_v[j-1] = first;
      end
      got[b] = byte_v;
    end

    exp_bits = 10'b1101001010;
    check({tag, "_sync_bits"}, 128'(bits0), 128'(exp_bits));
    hdr_got = {got[0], got[1], got[2], got[3], got[4], got[5], got[6], got[7], got[8]};
    check({tag, "_header"}, 128'(hdr_got), 128'(vecs[v].hdr));

    reg_err = 0;
    for (int r = 0; r < 32; r++)
      for (int k = 0; k < 4; k++) begin
        exp_b = 8'((32'(r) * vecs[v].mul) >> (24 - 8 * k));
        if (got[9 + 4 * r + k] !== exp_b) begin
          if (reg_err == 0)
            $display("FAIL %s_reg_byte%0d: got %0h expected %0h", tag, 9 + 4 * r + k,
                     got[9 + 4 * r + k], exp_b);
          reg_err++;
        end
      end
    check({tag, "_reg_bytes"}, 128'(reg_err), 128'(0));
    check({tag, "_bit_timing"}, 128'(tim_err), 128'(0));
    check({tag, "_busy_last_bit"}, 128'(last_busy), 128'(1));
    check({tag, "_busy_after"}, 128'(busy), 128'(0));
    check({tag, "_tx_idle"}, 128'(tx), 128'(1));
    check({tag, "_drop_cnt"}, 128'(drop_cnt), 128'(vecs[v].exp_drop));
  endtask

  initial begin
    vecs[0] = '{32'h0040_0000, 32'h2001_000A, 32'h0101_0101, 0,
                72'hA5_0040_0000_2001_000A, 8'd0};
    vecs[1] = '{32'h0040_0004, 32'h8C22_0004, 32'h1111_1111, 3,
                72'hA5_0040_0004_8C22_0004, 8'd3};
    vecs[2] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h9E37_79B9, 0,
                72'hA5_FFFF_FFFC_0000_0000, 8'd0};
    for (int i = 0; i < 32; i++) regs[i] = '0;

    apply_reset("por");

    for (int v = 0; v < 3; v++) begin
      apply_reset($sformatf("rst%0d", v));
      run_vector(v, $sformatf("v%0d", v));
    end

    // Drop counter saturates at 255
    apply_reset("sat_rst");
    @(negedge clk_in);
    trace_valid = 1'b1;
    @(negedge clk_in);
    trace_valid = 1'b0;
    for (int p = 0; p < 300; p++) begin
      @(negedge clk_in);
      trace_valid = 1'b1;
      @(negedge clk_in);
      trace_valid = 1'b0;
    end
    check("sat_drop_cnt", 128'(drop_cnt), 128'(255));
    check("sat_busy", 128'(busy), 128'(1));

    // Reset during the start bit of byte 50
    apply_reset("mid_pre");
    @(negedge clk_in);
    trace_valid = 1'b1;
    @(negedge clk_in);
    trace_valid = 1'b0;
    repeat (32 + 50 * 10 * CPB + 2) @(negedge clk_in);
    check("mid_start_bit", 128'(tx), 128'(0));
    check("mid_busy", 128'(busy), 128'(1));
    apply_reset("mid_rst");
    run_vector(0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trace_uart_tx.md
Name: trace_uart_tx

Overview:
- Hardware trace transmitter for the single-cycle MIPS CPU (sccomp_dataflow) on the board.
- On each trace request it snapshots pc, inst and all 32 general registers, then streams one binary frame over a UART 8N1 line to the host.
- Host-side tooling rebuilds the same pc/instr/regfile0..31 log that simulation writes to result.txt.
- Sits beside the CPU: stalls it during the register snapshot, and reads registers through a combinational debug read port on the register file.

Parameters:
- CLKS_PER_BIT, 868, clk_in cycles per UART bit (100 MHz / 115200); legal range >= 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk_in  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- trace_valid  input  1  one-cycle request: capture the current architectural state.
- pc  input  32  CPU program counter, sampled with trace_valid.
- inst  input  32  CPU current instruction, sampled with trace_valid.
- dbg_addr  output  5  register index for the debug read port.
- dbg_data  input  32  register contents at dbg_addr, combinational same cycle.
- stall_req  output  1  high while registers are being snapshotted; the CPU must hold its state.
- busy  output  1  high whenever state != IDLE.
- drop_cnt  output  8  number of requests dropped while busy, saturating.
- tx  output  1  UART serial line; idles high.

Behaviour:
- Reset (async, any state) values:
  - state = IDLE; tx = 1; stall_req = 0; busy = 0; dbg_addr = 0; drop_cnt = 0.
  - All counters cleared. Snapshot buffer contents are don't-care.
  - A frame in progress is abandoned; there is no partial resume.
- States: IDLE -> SNAP -> SEND -> IDLE.
- IDLE:
  - tx = 1.
  - At an edge with trace_valid = 1: latch pc and inst, set idx = 0, go to SNAP.
- SNAP (exactly 32 cycles):
  - dbg_addr = idx; stall_req = 1 combinationally from state.
  - Each edge stores dbg_data into buf[idx] and increments idx.
  - At the edge storing idx 31, go to SEND with byte_idx = 0.
  - stall_req first asserts the cycle after the accepting edge.
  - Register 0 is stored as read; it is not forced to zero.
- SEND: 137 bytes in this order:
  - SYNC_BYTE.
  - pc, 4 bytes, MSB first.
  - inst, 4 bytes, MSB first.
  - buf[0]..buf[31], 4 bytes each, MSB first.
- Byte framing:
  - One start bit (0), 8 data bits LSB first, one stop bit (1).
  - Each bit lasts exactly CLKS_PER_BIT cycles; there is no gap between bytes.
  - The start bit of byte 0 begins the cycle after SNAP ends.
- Frame length: 137 * 10 * CLKS_PER_BIT cycles. At the edge ending the last stop bit, state returns to IDLE.
- Drops:
  - trace_valid while state != IDLE is ignored for capture and increments drop_cnt, saturating at 255.
  - This includes the final SEND cycle; back-to-back acceptance needs at least one IDLE cycle.
- pc and inst changes after the accepting edge do not affect the frame.
- Bit counter width: ceil(log2(CLKS_PER_BIT)) bits, wrapping at CLKS_PER_BIT-1 to 0.

Test Plan:
- Reset: assert reset mid-cycle without a clock edge -> tx = 1, busy = 0, stall_req = 0, drop_cnt = 0 immediately.
- Single frame, CLKS_PER_BIT = 4: pc = 0x00400000, inst = 0x2001000A, reg[i] = i*0x01010101, one trace_valid pulse. Required response:
  - stall_req high exactly 32 cycles; dbg_addr steps 0..31.
  - Decoded bytes: A5 00 40 00 00 20 01 00 0A 00 00 00 00 01 01 01 01 ... 1F 1F 1F 1F (137 total).
  - busy falls 5480 cycles after SNAP ends.
- Bit timing, CLKS_PER_BIT = 4: each bit exactly 4 cycles wide; byte A5 appears on tx as 0,1,0,1,0,0,1,0,1,1 (start, LSB..MSB, stop).
- Drop: 3 trace_valid pulses during SEND -> drop_cnt = 3, frame unchanged. 300 pulses while busy -> drop_cnt = 255.
- Input stability: change pc and inst every cycle after acceptance -> transmitted pc and inst equal the values at the accepting edge.
- Reset mid-frame: reset asserted during byte 50 -> tx = 1 at once. A new trace_valid after release yields a complete, correct 137-byte frame starting with A5.
